// File: rtl/hdmi_overlay_gen.sv
// Video timing generator with a single overlay window, colour-key and colour-bar modes.
// Every video output is registered one clock after the counter state it describes.
module hdmi_overlay_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CNT_W    = 12,
    parameter int OVL_W    = 64,
    parameter int OVL_H    = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] ovl_x,
    input  logic [CNT_W-1:0] ovl_y,
    input  logic [23:0]      bg_color,
    input  logic [23:0]      key_color,
    input  logic [23:0]      ovl_data,
    input  logic             ovl_valid,
    output logic             ovl_ready,
    input  logic             clear_underflow,
    output logic             DE,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic [23:0]      data,
    output logic             frame_start,
    output logic             underflow
);

    typedef enum logic [1:0] {
        MODE_BG     = 2'd0,
        MODE_OPAQUE = 2'd1,
        MODE_KEY    = 2'd2,
        MODE_BARS   = 2'd3
    } mode_e;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] X_MAX    = CNT_W'(H_ACTIVE - OVL_W);
    localparam logic [CNT_W-1:0] Y_MAX    = CNT_W'(V_ACTIVE - OVL_H);
    localparam logic [CNT_W-1:0] BAR_W    = CNT_W'(H_ACTIVE / 8);
    localparam logic [CNT_W:0]   OVL_W_EXT = (CNT_W+1)'(OVL_W);
    localparam logic [CNT_W:0]   OVL_H_EXT = (CNT_W+1)'(OVL_H);

    logic [CNT_W-1:0] h_count, v_count;
    logic [CNT_W-1:0] x_clamped, y_clamped, sx_sh, sy_sh, sx, sy;
    logic [CNT_W-1:0] bar_idx;
    mode_e            mode_sh, cur_mode;
    logic             frame_origin, active, in_win, hsync, vsync, take, starve;
    logic [23:0]      bar_color, pixel;

    always_ff @(posedge clock) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
        end else begin
            h_count <= h_count + 1'b1;
        end
    end

    assign frame_origin = (h_count == '0) && (v_count == '0);
    assign x_clamped    = (ovl_x > X_MAX) ? X_MAX : ovl_x;
    assign y_clamped    = (ovl_y > Y_MAX) ? Y_MAX : ovl_y;

    always_ff @(posedge clock) begin
        if (reset || frame_origin) begin
            mode_sh <= mode_e'(mode);
            sx_sh   <= x_clamped;
            sy_sh   <= y_clamped;
        end
    end

    // The origin pixel already belongs to the new frame, so it sees the freshly captured values.
    always_comb begin
        cur_mode = mode_sh;
        sx       = sx_sh;
        sy       = sy_sh;
        if (frame_origin) begin
            cur_mode = mode_e'(mode);
            sx       = x_clamped;
            sy       = y_clamped;
        end
    end

    assign active = (h_count < H_ACT) && (v_count < V_ACT);
    assign hsync  = (h_count >= HS_START) && (h_count < HS_END);
    assign vsync  = (v_count >= VS_START) && (v_count < VS_END);
    assign in_win = active
                  && (h_count >= sx) && ({1'b0, h_count} < ({1'b0, sx} + OVL_W_EXT))
                  && (v_count >= sy) && ({1'b0, v_count} < ({1'b0, sy} + OVL_H_EXT));

    assign ovl_ready = in_win && ((cur_mode == MODE_OPAQUE) || (cur_mode == MODE_KEY));
    assign take      = ovl_ready && ovl_valid;
    assign starve    = ovl_ready && !ovl_valid;
    assign bar_idx   = h_count / BAR_W;

    always_comb begin
        bar_color = 24'h000000;
        case (bar_idx)
            CNT_W'(0): bar_color = 24'hFFFFFF;
            CNT_W'(1): bar_color = 24'hFFFF00;
            CNT_W'(2): bar_color = 24'h00FFFF;
            CNT_W'(3): bar_color = 24'h00FF00;
            CNT_W'(4): bar_color = 24'hFF00FF;
            CNT_W'(5): bar_color = 24'hFF0000;
            CNT_W'(6): bar_color = 24'h0000FF;
            default:   bar_color = 24'h000000;
        endcase
    end

    // A starved window pixel falls back to the background; the window still advances.
    always_comb begin
        pixel = 24'h000000;
        if (active) begin
            case (cur_mode)
                MODE_BG:     pixel = bg_color;
                MODE_OPAQUE: pixel = take ? ovl_data : bg_color;
                MODE_KEY:    pixel = (take && (ovl_data != key_color)) ? ovl_data : bg_color;
                default:     pixel = bar_color;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            DE          <= 1'b0;
            HSYNC       <= ~HS_POL;
            VSYNC       <= ~VS_POL;
            data        <= 24'h000000;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            DE          <= active;
            HSYNC       <= hsync ? HS_POL : ~HS_POL;
            VSYNC       <= vsync ? VS_POL : ~VS_POL;
            data        <= pixel;
            frame_start <= frame_origin;
            underflow   <= starve | (underflow & ~clear_underflow);
        end
    end

endmodule

// File: doc/hdmi_overlay_gen.md
HDMI_OVERLAY_GEN -- requirements
Module: hdmi_overlay_gen

Interface
REQ-001 SHALL provide parameters (name, default, meaning), one per line:
- H_ACTIVE, 1920, active pixels per line
- H_FP / H_SYNC / H_BP, 88 / 44 / 148, horizontal front porch, sync width and back porch in clocks
- V_ACTIVE, 1080, active lines per frame
- V_FP / V_SYNC / V_BP, 4 / 5 / 36, vertical front porch, sync width and back porch in lines
- HS_POL / VS_POL, 1 / 1, asserted level of HSYNC / VSYNC
- CNT_W, 12, horizontal/vertical counter width
- OVL_W / OVL_H, 64 / 64, overlay window size in pixels
REQ-002 SHALL provide ports (name, direction, width, meaning), one per line:
- clock, in, 1, pixel clock; the single clock domain
- reset, in, 1, synchronous, active-high
- mode, in, 2, 0 background, 1 opaque overlay, 2 colour-key overlay, 3 colour bars
- ovl_x / ovl_y, in, CNT_W each, overlay top-left position
- bg_color / key_color, in, 24 each, background colour / transparent key colour
- ovl_data, in, 24, overlay pixel RGB
- ovl_valid, in, 1, ovl_data valid
- ovl_ready, out, 1, overlay pixel accepted this cycle
- clear_underflow, in, 1, clears the underflow flag
- DE / HSYNC / VSYNC, out, 1 each, video timing
- data, out, 24, pixel RGB
- frame_start, out, 1, one-cycle pulse on the first active pixel of a frame
- underflow, out, 1, sticky starvation flag

Function
REQ-003 SHALL keep hCount in 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; hCount SHALL increment every clock and wrap to 0.
REQ-004 SHALL keep vCount in 0..V_TOTAL-1, incremented only when hCount wraps; vCount SHALL wrap to 0 after V_TOTAL-1.
REQ-005 SHALL decode active as hCount<H_ACTIVE and vCount<V_ACTIVE.
REQ-006 SHALL assert hsync when hCount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
REQ-007 SHALL assert vsync when vCount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines.
REQ-008 SHALL drive HSYNC = hsync ? HS_POL : ~HS_POL, and likewise VSYNC from vsync and VS_POL.
REQ-009 SHALL register DE, HSYNC, VSYNC, data and frame_start, each exactly 1 cycle after the counter state it represents, all mutually aligned.
REQ-010 SHALL capture mode, ovl_x and ovl_y into shadow registers only when hCount=0 and vCount=0, or during reset; mid-frame input changes SHALL have no effect until the next frame.
REQ-011 SHALL clamp the shadow ovl_x to H_ACTIVE-OVL_W when it exceeds that value, and the shadow ovl_y to V_ACTIVE-OVL_H likewise.
REQ-012 SHALL decode in_win as active and hCount in [sx, sx+OVL_W) and vCount in [sy, sy+OVL_H), where sx/sy are the clamped shadows.
REQ-013 SHALL drive ovl_ready combinationally as in_win and (shadow mode is 1 or 2); a pixel SHALL be consumed only on ovl_valid and ovl_ready.
REQ-014 SHALL, when ovl_ready is high and ovl_valid is low, output bg_color for that pixel and set underflow; the window position SHALL still advance, with no pixel retry.
REQ-015 SHALL select the pixel source as follows:
- when not active: data 0
- mode 0: bg_color
- mode 1: overlay pixel inside the window, else bg_color
- mode 2: as mode 1, except ovl_data equal to key_color outputs bg_color
- mode 3: colour bars, ovl_ready never asserted
REQ-016 SHALL, in mode 3, index the bar as hCount/(H_ACTIVE/8), giving in order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-017 SHALL pulse frame_start for the output cycle of hCount=0, vCount=0.
REQ-018 SHALL keep underflow set until clear_underflow or reset; a simultaneous set and clear SHALL leave underflow at 1.

Reset
REQ-019 SHALL, while reset is high, force hCount=0 and vCount=0, and on the next edge force DE=0, data=0, frame_start=0, underflow=0, HSYNC=~HS_POL and VSYNC=~VS_POL.
REQ-020 SHALL, on reset asserted mid-frame, abort the frame; on the first clock after release it SHALL restart at hCount=0, vCount=0 with shadows reloaded.

Verification
Common parameters: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), OVL 2x2, polarities 1.
REQ-021 SHALL cover: mode 0, bg 123456 -> DE high 8 of 14 cycles on output lines 0-3; HSYNC high at hCount 10-11; VSYNC high through line 5; frame_start every 98 cycles.
REQ-022 SHALL cover: mode 1, ovl at (3,1), source always valid with incrementing data -> exactly 4 handshakes per frame at (3,1), (4,1), (3,2), (4,2); those pixels show source data; underflow stays 0.
REQ-023 SHALL cover: mode 1, ovl_valid held low -> data = bg_color at the window pixels; underflow rises and stays high until a clear_underflow pulse.
REQ-024 SHALL cover: mode 2, key 00FF00, source alternating 00FF00 / ABCDEF -> window pixels alternate bg_color / ABCDEF.
REQ-025 SHALL cover: ovl_x=7 and ovl_y=3 written mid-frame -> no change in the current frame; the next frame's window is clamped to (6,2).
REQ-026 SHALL cover: mode 3 -> bar colours change at every output pixel (width 1), in the order given in REQ-016.
